// File: rtl/encoder_emu_if.sv
// Command handshake bundle for encoder_emu: master issues detent commands, slave (encoder_emu) accepts them.
interface encoder_emu_if #(
   parameter int unsigned DIV_W = 16,
   parameter int unsigned CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_cnt;
   logic [DIV_W-1:0] phase_div;

   modport master (
      output cmd_valid, cmd_dir, cmd_cnt, phase_div,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_cnt, phase_div,
      output cmd_ready
   );
endinterface

// File: rtl/encoder_emu.sv
// Rotary-encoder emulator: emits cmd_cnt quadrature detents on e_clk/e_dt at a programmable phase rate.
// Define ENCODER_EMU_POS_EN to include the saturating position mirror on pos.
module encoder_emu #(
   parameter int unsigned DIV_W    = 16,
   parameter int unsigned CNT_W    = 8,
   parameter logic [9:0]  POS_INI  = 10'd0,
   parameter logic [9:0]  POS_MIN  = 10'd0,
   parameter logic [9:0]  POS_MAX  = 10'd1023,
   parameter logic [9:0]  POS_STEP = 10'd1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   encoder_emu_if.slave       cmd,
   output logic               e_clk,
   output logic               e_dt,
   output logic               busy,
   output logic               done,
   output logic [9:0]         pos
);

   typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] timer_q, timer_d;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             accept, tick, det_end, last_det;
   logic [1:0]       e_nxt;
   logic             busy_nxt, done_nxt;

   if (POS_MIN > POS_MAX || POS_INI < POS_MIN || POS_INI > POS_MAX || POS_STEP == 10'd0) begin : g_bad_pos_cfg
      $error("encoder_emu: inconsistent POS_* parameters");
   end

   assign cmd.cmd_ready = en && (state_q == IDLE);
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   // Equality compare lets an all-ones divider run the full 2^DIV_W cycles.
   assign tick          = (state_q != IDLE) && (timer_q == div_q);
   assign det_end       = tick && (state_q == PH4);
   assign last_det      = (rem_q == CNT_W'(1));
   assign dir_d         = accept ? cmd.cmd_dir : dir_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else if (en) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: if (accept && cmd.cmd_cnt != '0) begin
            state_d = PH1;
            timer_d = '0;
            rem_d   = cmd.cmd_cnt;
         end
         PH1: if (tick) state_d = PH2;
         PH2: if (tick) state_d = PH3;
         PH3: if (tick) state_d = PH4;
         PH4: if (tick) begin
            if (last_det) begin
               state_d = IDLE;
               rem_d   = '0;
            end else begin
               state_d = PH1;
               rem_d   = rem_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE) timer_d = tick ? '0 : timer_q + DIV_W'(1);
   end

   // Outputs are derived from the next state so the registered pins line up with the state they represent.
   always_comb begin
      e_nxt = 2'b11;
      case (state_d)
         PH1:     e_nxt = dir_d ? 2'b01 : 2'b10;
         PH2:     e_nxt = 2'b00;
         PH3:     e_nxt = dir_d ? 2'b10 : 2'b01;
         default: e_nxt = 2'b11;
      endcase
      busy_nxt = (state_d != IDLE);
      done_nxt = (accept && cmd.cmd_cnt == '0) || (det_end && last_det);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_clk   <= 1'b1;
         e_dt    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         timer_q <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         dir_q   <= 1'b0;
      end else if (en) begin
         {e_clk, e_dt} <= e_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         timer_q <= timer_d;
         rem_q   <= rem_d;
         if (accept) begin
            dir_q <= cmd.cmd_dir;
            div_q <= cmd.phase_div;
         end
      end
   end

`ifdef ENCODER_EMU_POS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pos <= POS_INI;
      else if (en && det_end) begin
         if (dir_q) begin
            if (pos < POS_MAX) pos <= pos + POS_STEP;
         end else if (pos > POS_MIN) begin
            pos <= pos - POS_STEP;
         end
      end
   end
`else
   assign pos = '0;
`endif

endmodule

// File: tb/tb_encoder_emu.sv
// Scoreboard bench for encoder_emu: a phase-table model queues the expected per-cycle outputs, a monitor pops and compares.
module tb_encoder_emu;
   localparam int unsigned DIV_W = 4;
   localparam int unsigned CNT_W = 8;

   typedef struct {
      logic [1:0] e;
      logic       busy;
      logic       done;
      logic [9:0] pos;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, en;
   logic e_clk, e_dt, busy, done;
   logic [9:0] pos;

   encoder_emu_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) cmd_if ();

   encoder_emu #(
      .DIV_W(DIV_W), .CNT_W(CNT_W),
      .POS_INI(10'd0), .POS_MIN(10'd0), .POS_MAX(10'd1023), .POS_STEP(10'd1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd_if),
      .e_clk(e_clk), .e_dt(e_dt), .busy(busy), .done(done), .pos(pos)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   exp_t last_exp;
   int   checks = 0, passes = 0;
   int   pos_m = 0;
   int   busy_cnt = 0, done_cnt = 0, dec = 0;
   int   busy_base, done_base, dec_base;
   logic en_prev = 1'b1;
   logic rand_en = 1'b0;
   logic prev_ok = 1'b0;
   logic [1:0] prev_e = 2'b11;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference: each detent is the four table codes, each repeated div+1 times; pos moves once per detent.
   task automatic model_cmd(input logic dir, input int cnt, input int div);
      logic [1:0] cw [4];
      logic [1:0] ccw[4];
      cw  = '{2'b01, 2'b00, 2'b10, 2'b11};
      ccw = '{2'b10, 2'b00, 2'b01, 2'b11};
      for (int d = 0; d < cnt; d++) begin
         for (int p = 0; p < 4; p++)
            for (int k = 0; k <= div; k++)
               q.push_back('{dir ? cw[p] : ccw[p], 1'b1, 1'b0, 10'(pos_m)});
`ifdef ENCODER_EMU_POS_EN
         if (dir && pos_m < 1023) pos_m++;
         else if (!dir && pos_m > 0) pos_m--;
`endif
      end
      q.push_back('{2'b11, 1'b0, 1'b1, 10'(pos_m)});
   endtask

   task automatic issue(input logic dir, input int cnt, input int div);
      int n = 0;
      @(negedge clk);
      en = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_dir   = dir;
      cmd_if.cmd_cnt   = CNT_W'(cnt);
      cmd_if.phase_div = DIV_W'(div);
      while (!cmd_if.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_if.cmd_ready) chk("ready_timeout", {31'd0, cmd_if.cmd_ready}, 32'd1);
      model_cmd(dir, cnt, div);
      busy_base = busy_cnt;
      done_base = done_cnt;
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_dir   = 1'($urandom);
      cmd_if.cmd_cnt   = CNT_W'($urandom);
      cmd_if.phase_div = DIV_W'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 4000) begin
         @(negedge clk);
         if (rand_en) en = ($urandom_range(0, 3) != 0);
         n++;
      end
      if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
      en = 1'b1;
   endtask

   task automatic wait_code(input logic [1:0] code);
      int n = 0;
      while ({e_clk, e_dt} != code && n < 500) begin
         @(negedge clk);
         n++;
      end
      if ({e_clk, e_dt} != code) chk("code_timeout", {30'd0, e_clk, e_dt}, {30'd0, code});
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_dir   = 1'b0;
      cmd_if.cmd_cnt   = '0;
      cmd_if.phase_div = '0;
      fork
         forever begin
            @(posedge clk);
            en_prev = en;
         end
         forever begin
            @(negedge clk);
            if (!rst_n) prev_ok = 1'b0;
            else begin
               if (prev_ok) begin
                  chk("gray", {31'd0, $countones({e_clk, e_dt} ^ prev_e) <= 1}, 32'd1);
                  if ({e_clk, e_dt} == 2'b11 && prev_e == 2'b10) dec++;
                  if ({e_clk, e_dt} == 2'b11 && prev_e == 2'b01) dec--;
               end
               prev_e = {e_clk, e_dt};
               prev_ok = 1'b1;
               if (busy) busy_cnt++;
               if (done && en_prev) done_cnt++;
               if (busy || done) begin
                  if (en_prev) begin
                     if (q.size() == 0) chk("unexpected_output", {30'd0, busy, done}, 32'd0);
                     else begin
                        last_exp = q.pop_front();
                        chk("stream", {18'd0, e_clk, e_dt, busy, done, pos},
                            {18'd0, last_exp.e, last_exp.busy, last_exp.done, last_exp.pos});
                     end
                  end else begin
                     chk("held", {18'd0, e_clk, e_dt, busy, done, pos},
                         {18'd0, last_exp.e, last_exp.busy, last_exp.done, last_exp.pos});
                  end
               end
            end
         end
         begin
            repeat (3) @(negedge clk);
            chk("rst_e",    {30'd0, e_clk, e_dt}, 32'd3);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_pos",  {22'd0, pos}, 32'd0);
            #1 rst_n = 1'b1;
            @(negedge clk);
            chk("ready_idle", {31'd0, cmd_if.cmd_ready}, 32'd1);

            // CCW one detent, div 0, at pos 0 (saturates)
            issue(1'b0, 1, 0);
            wait_done();
            chk("ccw_busy", busy_cnt - busy_base, 32'd4);
            chk("ccw_pos", {22'd0, pos}, 32'(pos_m));

            // cnt 0: immediate done, never busy
            issue(1'b1, 0, 5);
            wait_done();
            chk("cnt0_busy", busy_cnt - busy_base, 32'd0);

            // CW two detents, div 3
            issue(1'b1, 2, 3);
            wait_done();
            repeat (3) @(negedge clk);
            chk("cw2_busy", busy_cnt - busy_base, 32'd32);
            chk("cw2_done", done_cnt - done_base, 32'd1);
            chk("cw2_pos", {22'd0, pos}, 32'(pos_m));

            // en low for 5 cycles inside PH3, div 7
            issue(1'b1, 1, 7);
            wait_code(2'b10);
            repeat (2) @(negedge clk);
            en = 1'b0;
            repeat (3) @(negedge clk);
            chk("frozen_ph3", {30'd0, e_clk, e_dt}, 32'd2);
            repeat (2) @(negedge clk);
            en = 1'b1;
            wait_done();
            chk("freeze_busy", busy_cnt - busy_base, 32'd37);

            // all-ones divider: 2^DIV_W cycles per phase
            issue(1'b0, 1, 15);
            wait_done();
            chk("divmax_busy", busy_cnt - busy_base, 32'd64);

            // reset in the middle of PH2
            issue(1'b1, 3, 3);
            wait_code(2'b00);
            #3 rst_n = 1'b0;
            #1;
            chk("abort_e",    {30'd0, e_clk, e_dt}, 32'd3);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_done", {31'd0, done}, 32'd0);
            q.delete();
            pos_m = 0;
            chk("abort_pos", {22'd0, pos}, 32'd0);
            repeat (2) @(negedge clk);
            #1 rst_n = 1'b1;
            chk("abort_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
            done_base = done_cnt;
            repeat (10) @(negedge clk);
            chk("abort_nodone", done_cnt - done_base, 32'd0);

            // loopback through a detent decoder
            dec_base = dec;
            issue(1'b1, 10, 1);
            wait_done();
            chk("loop_cw10", dec - dec_base, 32'd10);
            issue(1'b0, 3, 2);
            wait_done();
            chk("loop_ccw3", dec - dec_base, 32'd7);
            chk("loop_pos", {22'd0, pos}, 32'(pos_m));

            rand_en = 1'b1;
            repeat (25) begin
               issue(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 6));
               wait_done();
            end
            rand_en = 1'b0;
            repeat (3) @(negedge clk);
            chk("queue_empty", q.size(), 32'd0);
         end
      join_any
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
